// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the ALU execute stage.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOTA = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

endpackage

// File: rtl/alu_exec_stage_core.sv
// Purely combinational ALU: {op, a, b} -> {result, flags, err}.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           ovf;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        flags  = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOTA: result = ~a;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra MSB of the widened difference is the unsigned borrow.
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_PASS: result = a;
            default: err = 1'b1;
        endcase
        if (!err) begin
            flags[F_Z] = (result == '0);
            flags[F_N] = result[WIDTH-1];
            flags[F_C] = carry;
            flags[F_V] = ovf;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: valid/ready command input, in-order result FIFO output.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_op,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_result,
    output logic [3:0]                  out_flags,
    output logic                        out_err,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 5;

    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;
    logic             core_err;
    logic [EW-1:0]    new_entry;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] remaining;
    logic          out_valid_q, out_valid_d;
    logic [EW-1:0] head_q, head_d;
    logic          push, pop;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (core_result),
        .flags  (core_flags),
        .err    (core_err)
    );

    assign new_entry = {core_err, core_flags, core_result};

    assign in_ready = (count_q < CW'(FIFO_DEPTH)) | out_ready;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid_q & out_ready;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        remaining = pop ? (count_q - CW'(1)) : count_q;
        head_d    = head_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d     = remaining + CW'(push);
        out_valid_d = (count_d != '0);
        // The head register is loaded with whatever sits at the head after this edge,
        // bypassing memory when the incoming command lands in an otherwise empty FIFO.
        if (push && (remaining == '0)) begin
            head_d = new_entry;
        end else if (remaining != '0) begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = head_q[WIDTH-1:0];
    assign out_flags  = head_q[WIDTH+3:WIDTH];
    assign out_err    = head_q[WIDTH+4];
    assign count      = count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with hand-computed expected results.
module tb_alu_exec_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_flags;
    logic       out_err;
    logic [1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_stage #(.WIDTH(8), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_err    (out_err),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 3'b000;
        in_a     = 8'h00;
        in_b     = 8'h00;
    endtask

    task automatic check_head(input string tag, input logic [7:0] r, input logic [3:0] f,
                              input logic e);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"}, 32'(out_result), 32'(r));
        chk({tag, ".flags"}, 32'(out_flags), 32'(f));
        chk({tag, ".err"}, 32'(out_err), 32'(e));
    endtask

    // Single command with out_ready=1: visible right after the accepting edge, gone one edge later.
    task automatic one_shot(input string tag, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] r, input logic [3:0] f,
                            input logic e);
        out_ready = 1'b1;
        drive(op, a, b);
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".pre_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_head(tag, r, f, e);
        chk({tag, ".count"}, 32'(count), 32'd1);
        idle();
        @(posedge clk);
        #1;
        chk({tag, ".drained"}, 32'(out_valid), 32'd0);
        chk({tag, ".count0"}, 32'(count), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result", 32'(out_result), 32'd0);
        chk("rst.flags", 32'(out_flags), 32'd0);
        chk("rst.err", 32'(out_err), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        one_shot("and",   3'b000, 8'h0C, 8'h0A, 8'h08, 4'b0000, 1'b0);
        one_shot("addwr", 3'b100, 8'hFF, 8'h01, 8'h00, 4'b1010, 1'b0);
        one_shot("subov", 3'b101, 8'h80, 8'h01, 8'h7F, 4'b0001, 1'b0);
        one_shot("subbr", 3'b101, 8'h01, 8'h02, 8'hFF, 4'b0110, 1'b0);
        one_shot("or",    3'b001, 8'h0F, 8'hF0, 8'hFF, 4'b0100, 1'b0);
        one_shot("xor",   3'b010, 8'h5A, 8'h5A, 8'h00, 4'b1000, 1'b0);
        one_shot("nota",  3'b011, 8'h0F, 8'h33, 8'hF0, 4'b0100, 1'b0);
        one_shot("pass",  3'b110, 8'h00, 8'hFF, 8'h00, 4'b1000, 1'b0);
        one_shot("addov", 3'b100, 8'h7F, 8'h01, 8'h80, 4'b0101, 1'b0);
        one_shot("ill",   3'b111, 8'h55, 8'h55, 8'h00, 4'b0000, 1'b1);

        // Back-to-back throughput with the consumer always ready.
        out_ready = 1'b1;
        drive(3'b100, 8'h01, 8'h01);
        @(posedge clk);
        #1;
        check_head("bb0", 8'h02, 4'b0000, 1'b0);
        drive(3'b100, 8'h02, 8'h02);
        #1;
        chk("bb1.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check_head("bb1", 8'h04, 4'b0000, 1'b0);
        chk("bb1.count", 32'(count), 32'd1);
        idle();
        @(posedge clk);
        #1;
        chk("bb.drained", 32'(out_valid), 32'd0);

        // Backpressure: fill, stall the third command, then simultaneous push and pop.
        out_ready = 1'b0;
        drive(3'b100, 8'h01, 8'h02);
        @(posedge clk);
        #1;
        chk("bp.count1", 32'(count), 32'd1);
        check_head("bp.h1", 8'h03, 4'b0000, 1'b0);
        drive(3'b111, 8'h55, 8'h55);
        @(posedge clk);
        #1;
        chk("bp.count2", 32'(count), 32'd2);
        check_head("bp.h1b", 8'h03, 4'b0000, 1'b0);
        drive(3'b010, 8'hF0, 8'h0F);
        #1;
        chk("bp.full_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("bp.stalled", 32'(count), 32'd2);
        check_head("bp.h1c", 8'h03, 4'b0000, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp.ready_back", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp.pushpop", 32'(count), 32'd2);
        check_head("bp.h2", 8'h00, 4'b0000, 1'b1);
        idle();
        @(posedge clk);
        #1;
        chk("bp.count_after", 32'(count), 32'd1);
        check_head("bp.h3", 8'hFF, 4'b0100, 1'b0);
        @(posedge clk);
        #1;
        chk("bp.empty", 32'(out_valid), 32'd0);
        chk("bp.hold_result", 32'(out_result), 32'hFF);
        chk("bp.hold_flags", 32'(out_flags), 32'h4);

        // Reset with two results buffered.
        out_ready = 1'b0;
        drive(3'b100, 8'h11, 8'h11);
        drive(3'b100, 8'h22, 8'h22);
        @(posedge clk);
        #1;
        chk("mrst.pre_count", 32'(count), 32'd2);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mrst.count", 32'(count), 32'd0);
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.result", 32'(out_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        chk("mrst.out_valid_rel", 32'(out_valid), 32'd0);
        one_shot("mrst.add", 3'b100, 8'h10, 8'h20, 8'h30, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
